upsample_zs: RTL and testbench

//   Zero-stuffing upsampler directly upstream of the transposed-form FIR in the interpolation chain.

---
 rtl/upsample_zs.sv | 131 +++++++++++++
 tb/tb_upsample_zs.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/upsample_zs.sv
`default_nettype none
// ============================================================================
// Module   : upsample_zs
// Purpose  : Zero-stuffing / sample-and-hold upsampler feeding the interpolation FIR.
// Revision : 1.0  initial release
// ============================================================================
module upsample_zs #(
    parameter int DATA_WIDTH = 5,
    parameter int UP_FACTOR  = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         en,
    input  logic                         mode,
    input  logic [DATA_WIDTH-1:0]        in_data,
    input  logic                         in_valid,
    output logic                         in_ready,
    output logic [DATA_WIDTH-1:0]        out,
    output logic                         out_sop,
    output logic [$clog2(UP_FACTOR)-1:0] phase,
    output logic                         underrun,
    input  logic                         clr_underrun
);

    localparam int c_ph_w = $clog2(UP_FACTOR);
    localparam int c_aw   = $clog2(FIFO_DEPTH);
    localparam logic [c_ph_w-1:0] c_last = c_ph_w'(UP_FACTOR - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t                  r_state;
    logic [c_ph_w-1:0]       r_cnt;
    logic [DATA_WIDTH-1:0]   r_out;
    logic [DATA_WIDTH-1:0]   r_hold;
    logic                    r_sop;
    logic [c_ph_w-1:0]       r_phase;
    logic                    r_underrun;

    logic [DATA_WIDTH-1:0]   r_mem [FIFO_DEPTH];
    logic [c_aw:0]           r_wptr;
    logic [c_aw:0]           r_rptr;

    logic                    w_empty;
    logic                    w_full;
    logic                    w_push;
    logic                    w_slot0;
    logic                    w_pop;
    logic [DATA_WIDTH-1:0]   w_head;
    logic [DATA_WIDTH-1:0]   w_fill;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign w_empty = (r_wptr == r_rptr);
    assign w_full  = (r_wptr[c_aw] != r_rptr[c_aw]) &&
                     (r_wptr[c_aw-1:0] == r_rptr[c_aw-1:0]);
    assign w_push  = in_valid && !w_full;
    assign w_slot0 = (r_state == S_RUN) && (r_cnt == '0);
    assign w_pop   = w_slot0 && !w_empty;
    assign w_head  = r_mem[r_rptr[c_aw-1:0]];
    assign w_fill  = mode ? r_hold : '0;

    assign in_ready = !w_full;
    assign out      = r_out;
    assign out_sop  = r_sop;
    assign phase    = r_phase;
    assign underrun = r_underrun;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr[c_aw-1:0]] <= in_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_out      <= '0;
            r_hold     <= '0;
            r_sop      <= 1'b0;
            r_phase    <= '0;
            r_underrun <= 1'b0;
        end else begin
            // A starved phase-0 slot wins over a simultaneous clear.
            if (w_slot0 && w_empty) r_underrun <= 1'b1;
            else if (clr_underrun)  r_underrun <= 1'b0;

            case (r_state)
                S_RUN, S_DRAIN: begin
                    r_phase <= r_cnt;
                    r_sop   <= (r_cnt == '0);
                    if (w_pop) begin
                        r_out  <= w_head;
                        r_hold <= w_head;
                    end else begin
                        r_out  <= w_fill;
                    end
                    r_cnt <= (r_cnt == c_last) ? '0 : r_cnt + 1'b1;
                    if (r_state == S_RUN) begin
                        if (!en) r_state <= (r_cnt == c_last) ? S_IDLE : S_DRAIN;
                    end else if (r_cnt == c_last) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_out   <= '0;
                    r_sop   <= 1'b0;
                    r_phase <= '0;
                    r_cnt   <= '0;
                    if (en && !w_empty) r_state <= S_RUN;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_upsample_zs.sv
`default_nettype none
// ============================================================================
// Module   : tb_upsample_zs
// Purpose  : Scoreboard bench for upsample_zs (L=4, DEPTH=4, 5-bit samples).
// Revision : 1.0  initial release
// ============================================================================
module tb_upsample_zs;

    localparam int DW = 5;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          en;
    logic          mode;
    logic [DW-1:0] in_data;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] out;
    logic          out_sop;
    logic [1:0]    phase;
    logic          underrun;
    logic          clr_underrun;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [DW-1:0] d;
        logic          sop;
        logic [1:0]    ph;
    } exp_t;

    exp_t q[$];

    upsample_zs #(.DATA_WIDTH(DW), .UP_FACTOR(4), .FIFO_DEPTH(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .en           (en),
        .mode         (mode),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .out          (out),
        .out_sop      (out_sop),
        .phase        (phase),
        .underrun     (underrun),
        .clr_underrun (clr_underrun)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; en = 1'b0; mode = 1'b0;
        in_valid = 1'b0; in_data = '0; clr_underrun = 1'b0;
        q.delete();
        repeat (2) tick();
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic push_sample(input logic [DW-1:0] v);
        in_valid = 1'b1;
        in_data  = v;
        tick();
        in_valid = 1'b0;
    endtask

    // Expected frame: real sample at phase 0, then zero or held value.
    task automatic expect_frame(input logic [DW-1:0] s, input logic m);
        exp_t e;
        for (int k = 0; k < 4; k++) begin
            e.d   = (k == 0 || m) ? s : '0;
            e.sop = (k == 0);
            e.ph  = 2'(k);
            q.push_back(e);
        end
    endtask

    task automatic test_reset();
        do_reset();
        total++;
        if (out !== 5'd0 || out_sop !== 1'b0 || phase !== 2'd0 || underrun !== 1'b0 || in_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_init: out=%0d sop=%0b ph=%0d unr=%0b rdy=%0b, want 0 0 0 0 1",
                     out, out_sop, phase, underrun, in_ready);
        end
        for (int i = 1; i <= 4; i++) push_sample(5'(i));
        en = 1'b1;
        repeat (3) tick();   // IDLE->RUN, phase 0 pop, phase 1: three entries left
        #2 rst_n = 1'b0;
        #1;
        total++;
        if (out !== 5'd0 || phase !== 2'd0 || out_sop !== 1'b0 || underrun !== 1'b0) begin
            bad++;
            $display("FAIL reset_async: out=%0d ph=%0d sop=%0b unr=%0b, want 0 0 0 0",
                     out, phase, out_sop, underrun);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_ready: in_ready=%0b want 1", in_ready);
        end
        // FIFO contents must be gone: with en held high nothing may start.
        for (int i = 0; i < 6; i++) begin
            tick();
            total++;
            if (out !== 5'd0 || out_sop !== 1'b0) begin
                bad++;
                $display("FAIL reset_flushed[%0d]: out=%0d sop=%0b want 0 0", i, out, out_sop);
            end
        end
        en = 1'b0;
    endtask

    task automatic test_stream(input logic m);
        logic signed [DW-1:0] vals [3];
        exp_t e;
        vals[0] = 5'sd3; vals[1] = -5'sd2; vals[2] = 5'sd7;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            push_sample(vals[i]);
            expect_frame(vals[i], m);
        end
        mode = m;
        en   = 1'b1;
        tick();
        total++;
        if (out !== 5'd0 || out_sop !== 1'b0) begin
            bad++;
            $display("FAIL stream_m%0b_start: out=%0d sop=%0b want 0 0", m, out, out_sop);
        end
        for (int i = 0; i < 12; i++) begin
            tick();
            e = q.pop_front();
            total++;
            if (out !== e.d || out_sop !== e.sop || phase !== e.ph) begin
                bad++;
                $display("FAIL stream_m%0b[%0d]: out=%0d sop=%0b ph=%0d want out=%0d sop=%0b ph=%0d",
                         m, i, $signed(out), out_sop, phase, $signed(e.d), e.sop, e.ph);
            end
            if (i == 8) en = 1'b0;
        end
        tick();
        total++;
        if (out !== 5'd0 || out_sop !== 1'b0 || phase !== 2'd0 || underrun !== 1'b0) begin
            bad++;
            $display("FAIL stream_m%0b_end: out=%0d sop=%0b ph=%0d unr=%0b want 0 0 0 0",
                     m, out, out_sop, phase, underrun);
        end
    endtask

    task automatic test_backpressure();
        exp_t e;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_data  = 5'(i + 1);
            total++;
            if (in_ready !== 1'b1) begin
                bad++;
                $display("FAIL bp_ready_fill[%0d]: in_ready=%0b want 1", i, in_ready);
            end
            tick();
            expect_frame(5'(i + 1), 1'b0);
        end
        expect_frame(5'd5, 1'b0);
        in_data = 5'd5;
        for (int i = 0; i < 2; i++) begin
            total++;
            if (in_ready !== 1'b0) begin
                bad++;
                $display("FAIL bp_full[%0d]: in_ready=%0b want 0", i, in_ready);
            end
            tick();
        end
        en = 1'b1;
        tick();
        for (int i = 0; i < 20; i++) begin
            tick();
            e = q.pop_front();
            total++;
            if (out !== e.d || out_sop !== e.sop || phase !== e.ph) begin
                bad++;
                $display("FAIL bp_stream[%0d]: out=%0d sop=%0b ph=%0d want out=%0d sop=%0b ph=%0d",
                         i, out, out_sop, phase, e.d, e.sop, e.ph);
            end
            if (i == 0) begin
                total++;
                if (in_ready !== 1'b1) begin
                    bad++;
                    $display("FAIL bp_slot_freed: in_ready=%0b want 1", in_ready);
                end
            end
            if (i == 1) begin
                total++;
                if (in_ready !== 1'b0) begin
                    bad++;
                    $display("FAIL bp_fifth_taken: in_ready=%0b want 0", in_ready);
                end
                in_valid = 1'b0;
            end
            if (i == 16) en = 1'b0;
        end
    endtask

    task automatic test_underrun();
        exp_t e;
        do_reset();
        push_sample(5'd6);
        expect_frame(5'd6, 1'b0);
        expect_frame(5'd0, 1'b0);   // starved frame: zero with sop at phase 0
        en = 1'b1;
        tick();
        for (int i = 0; i < 8; i++) begin
            tick();
            e = q.pop_front();
            total++;
            if (out !== e.d || out_sop !== e.sop || phase !== e.ph) begin
                bad++;
                $display("FAIL unr_stream[%0d]: out=%0d sop=%0b ph=%0d want out=%0d sop=%0b ph=%0d",
                         i, out, out_sop, phase, e.d, e.sop, e.ph);
            end
            total++;
            if (underrun !== (i >= 4)) begin
                bad++;
                $display("FAIL unr_flag[%0d]: underrun=%0b want %0b", i, underrun, (i >= 4));
            end
            if (i == 3) clr_underrun = 1'b1;   // held across the starved edge: set must win
            if (i == 4) begin
                clr_underrun = 1'b0;
                en = 1'b0;
            end
        end
        tick();
        total++;
        if (underrun !== 1'b1) begin
            bad++;
            $display("FAIL unr_sticky: underrun=%0b want 1", underrun);
        end
        clr_underrun = 1'b1;
        tick();
        clr_underrun = 1'b0;
        total++;
        if (underrun !== 1'b0) begin
            bad++;
            $display("FAIL unr_clear: underrun=%0b want 0", underrun);
        end
    endtask

    task automatic test_en_drop();
        exp_t e;
        do_reset();
        push_sample(5'd8);
        push_sample(-5'sd5);
        expect_frame(5'd8, 1'b0);
        for (int pass = 0; pass < 2; pass++) begin
            en = 1'b1;
            tick();
            for (int i = 0; i < 4; i++) begin
                tick();
                e = q.pop_front();
                total++;
                if (out !== e.d || out_sop !== e.sop || phase !== e.ph) begin
                    bad++;
                    $display("FAIL endrop%0d[%0d]: out=%0d sop=%0b ph=%0d want out=%0d sop=%0b ph=%0d",
                             pass, i, $signed(out), out_sop, phase, $signed(e.d), e.sop, e.ph);
                end
                if (i == 0) en = 1'b0;
            end
            tick();
            total++;
            if (out !== 5'd0 || out_sop !== 1'b0 || phase !== 2'd0 || underrun !== 1'b0) begin
                bad++;
                $display("FAIL endrop%0d_idle: out=%0d sop=%0b ph=%0d unr=%0b want 0 0 0 0",
                         pass, out, out_sop, phase, underrun);
            end
            // The untouched second sample must still be queued.
            expect_frame(-5'sd5, 1'b0);
        end
        q.delete();
    endtask

    initial begin
        test_reset();
        test_stream(1'b0);
        test_stream(1'b1);
        test_backpressure();
        test_underrun();
        test_en_drop();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, want completion");
        $fatal(1);
    end

endmodule
`default_nettype wire
